// File: rtl/ir_nec_decoder_pkg.sv
// Shared definitions for the NEC infrared decoder.
//   ir_state_t   : frame-decoder FSM states
//   NEC_*_US     : nominal NEC mark/space widths in microseconds
//   win_lo/win_hi: tolerance window bounds around a nominal width
//   nec_frame_t  : received 32-bit frame, addr in the low byte
`timescale 1ns/1ps
package ir_nec_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_STOP
    } ir_state_t;

    localparam int NEC_LEAD_MARK_US  = 9000;
    localparam int NEC_LEAD_SPACE_US = 4500;
    localparam int NEC_RPT_SPACE_US  = 2250;
    localparam int NEC_BIT_MARK_US   = 562;
    localparam int NEC_ZERO_SPACE_US = 562;
    localparam int NEC_ONE_SPACE_US  = 1687;
    localparam int NEC_STOP_MARK_US  = 562;

    typedef struct packed {
        logic [7:0] ncmd;
        logic [7:0] cmd;
        logic [7:0] naddr;
        logic [7:0] addr;
    } nec_frame_t;

    function automatic int win_lo(input int nominal, input int tol);
        return nominal - (nominal * tol) / 100;
    endfunction

    function automatic int win_hi(input int nominal, input int tol);
        return nominal + (nominal * tol) / 100;
    endfunction

endpackage

// File: rtl/ir_nec_decoder_pulse_timer.sv
// Input conditioning and pulse-width timebase for the NEC decoder.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ir_i          : raw asynchronous IR receiver output (idle high)
//   rise_o/fall_o : single-cycle strobes on synchronised edges
//   tick_us_o     : one-cycle strobe every CLK_HZ/1e6 clocks
//   width_us_o    : microseconds since the last edge, saturating at 16'hFFFF
`timescale 1ns/1ps
module ir_nec_decoder_pulse_timer #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ir_i,
    output logic        rise_o,
    output logic        fall_o,
    output logic        tick_us_o,
    output logic [15:0] width_us_o
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = $clog2(DIV);

    logic          meta_q, sync_q, prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   width_q, width_d;

    // Synchroniser and previous-sample registers reset to the idle (high) level
    // so that releasing reset never manufactures an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            pre_q   <= '0;
            width_q <= '0;
        end else begin
            meta_q  <= ir_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pre_q   <= pre_d;
            width_q <= width_d;
        end
    end

    assign rise_o    = sync_q & ~prev_q;
    assign fall_o    = ~sync_q & prev_q;
    assign tick_us_o = (pre_q == PW'(DIV - 1));

    always_comb begin
        pre_d   = tick_us_o ? '0 : pre_q + 1'b1;
        width_d = width_q;
        if (rise_o || fall_o) begin
            width_d = '0;
        end else if (tick_us_o && (width_q != 16'hFFFF)) begin
            width_d = width_q + 16'd1;
        end
    end

    assign width_us_o = width_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder with checksum validation, repeat detection and
// held-key tracking.
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   iIRDA        : raw IR receiver output, active-low, asynchronous
//   oDATA        : last valid frame {ncmd,cmd,naddr,addr}
//   oDATA_READY  : one-cycle pulse when oDATA takes a new valid frame
//   oREPEAT      : one-cycle pulse on a repeat frame while oHELD is set
//   oHELD        : a valid frame or repeat arrived within REPEAT_WIN_MS
//   oERR         : one-cycle pulse on width/timeout/checksum failure
// TIME_DIV divides every nominal width, the timeout and the hold window; it is
// 1 in hardware and larger only to compress time in simulation.
`timescale 1ns/1ps
module ir_nec_decoder
    import ir_nec_decoder_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TOL_PCT        = 25,
    parameter int CHECK_CMD_INV  = 1,
    parameter int CHECK_ADDR_INV = 0,
    parameter int REPEAT_WIN_MS  = 120,
    parameter int TIMEOUT_US     = 12000,
    parameter int TIME_DIV       = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iIRDA,
    output logic [31:0] oDATA,
    output logic        oDATA_READY,
    output logic        oREPEAT,
    output logic        oHELD,
    output logic        oERR
);

    localparam int LM_N      = NEC_LEAD_MARK_US  / TIME_DIV;
    localparam int LS_N      = NEC_LEAD_SPACE_US / TIME_DIV;
    localparam int RS_N      = NEC_RPT_SPACE_US  / TIME_DIV;
    localparam int BM_N      = NEC_BIT_MARK_US   / TIME_DIV;
    localparam int ZS_N      = NEC_ZERO_SPACE_US / TIME_DIV;
    localparam int OS_N      = NEC_ONE_SPACE_US  / TIME_DIV;
    localparam int SM_N      = NEC_STOP_MARK_US  / TIME_DIV;
    localparam int TIMEOUT_N = TIMEOUT_US / TIME_DIV;
    localparam int HOLD_N    = (REPEAT_WIN_MS * 1000) / TIME_DIV;

    function automatic logic in_win(input int w, input int nominal);
        return (w >= win_lo(nominal, TOL_PCT)) && (w <= win_hi(nominal, TOL_PCT));
    endfunction

    logic        rise, fall, tick_us, edge_any;
    logic [15:0] width_us;
    int          w;

    ir_nec_decoder_pulse_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .clk_i      (iCLK),
        .rst_ni     (iRST_n),
        .ir_i       (iIRDA),
        .rise_o     (rise),
        .fall_o     (fall),
        .tick_us_o  (tick_us),
        .width_us_o (width_us)
    );

    assign edge_any = rise | fall;
    assign w        = int'({16'd0, width_us});

    logic in_lm, in_ls, in_rs, in_bm, in_zs, in_os, in_sm, timeout;
    assign in_lm = in_win(w, LM_N);
    assign in_ls = in_win(w, LS_N);
    assign in_rs = in_win(w, RS_N);
    assign in_bm = in_win(w, BM_N);
    assign in_zs = in_win(w, ZS_N);
    assign in_os = in_win(w, OS_N);
    assign in_sm = in_win(w, SM_N);

    ir_state_t state_q, state_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [31:0] shift_q, shift_d;

    assign timeout = (state_q != IDLE) && (w > TIMEOUT_N);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (edge_any) begin
            case (state_q)
                IDLE:       state_d = fall ? LEAD_MARK : IDLE;
                LEAD_MARK:  state_d = (rise && in_lm) ? LEAD_SPACE : IDLE;
                LEAD_SPACE: state_d = (fall && in_ls) ? BIT_MARK :
                                      (fall && in_rs) ? RPT_STOP : IDLE;
                BIT_MARK:   state_d = (rise && in_bm) ? BIT_SPACE : IDLE;
                BIT_SPACE:  state_d = !(fall && (in_zs || in_os)) ? IDLE :
                                      (bit_idx_q == 5'd31) ? STOP_MARK : BIT_MARK;
                default:    state_d = IDLE;
            endcase
        end
    end

    logic err_ev, frame_done, rpt_done, bit_en, bit_val, idx_clr;

    always_comb begin
        err_ev     = 1'b0;
        frame_done = 1'b0;
        rpt_done   = 1'b0;
        bit_en     = 1'b0;
        bit_val    = 1'b0;
        idx_clr    = 1'b0;
        if (timeout) begin
            err_ev = 1'b1;
        end else if (edge_any) begin
            case (state_q)
                LEAD_MARK:  err_ev = !(rise && in_lm);
                LEAD_SPACE: begin
                    idx_clr = fall && in_ls;
                    err_ev  = !(fall && (in_ls || in_rs));
                end
                BIT_MARK:   err_ev = !(rise && in_bm);
                BIT_SPACE: begin
                    bit_en  = fall && (in_zs || in_os);
                    bit_val = in_os;
                    err_ev  = !bit_en;
                end
                STOP_MARK: begin
                    frame_done = rise && in_sm;
                    err_ev     = !frame_done;
                end
                RPT_STOP: begin
                    rpt_done = rise && in_sm;
                    err_ev   = !rpt_done;
                end
                default: ;
            endcase
        end
    end

    // Bits arrive LSB first: each new bit enters at [31] and after 32 shifts
    // the first bit sits at [0].
    assign shift_d   = {bit_val, shift_q[31:1]};
    assign bit_idx_d = idx_clr ? 5'd0 : (bit_en ? bit_idx_q + 5'd1 : bit_idx_q);

    always_ff @(posedge iCLK) begin
        if (bit_en) begin
            shift_q <= shift_d;
        end
    end

    nec_frame_t frame_s;
    logic       cmd_ok, addr_ok, frame_ok, frame_bad;
    assign frame_s   = shift_q;
    assign cmd_ok    = (CHECK_CMD_INV == 0)  || ((frame_s.cmd  ^ frame_s.ncmd)  == 8'hFF);
    assign addr_ok   = (CHECK_ADDR_INV == 0) || ((frame_s.addr ^ frame_s.naddr) == 8'hFF);
    assign frame_ok  = frame_done && cmd_ok && addr_ok;
    assign frame_bad = frame_done && !(cmd_ok && addr_ok);

    logic        held_q, held_d, hold_restart;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] data_q;
    logic        rdy_q, rpt_q, err_q;

    // A restart in the expiry cycle takes priority, so the key stays held.
    assign hold_restart = frame_ok || (rpt_done && held_q);

    always_comb begin
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;
        if (hold_restart) begin
            held_d     = 1'b1;
            hold_cnt_d = '0;
        end else if (held_q && tick_us) begin
            if (hold_cnt_q == 32'(HOLD_N - 1)) begin
                held_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            bit_idx_q  <= '0;
            held_q     <= 1'b0;
            hold_cnt_q <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
            rpt_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            bit_idx_q  <= bit_idx_d;
            held_q     <= held_d;
            hold_cnt_q <= hold_cnt_d;
            rdy_q      <= frame_ok;
            rpt_q      <= rpt_done && held_q;
            err_q      <= err_ev || frame_bad;
            if (frame_ok) begin
                data_q <= shift_q;
            end
        end
    end

    assign oDATA       = data_q;
    assign oDATA_READY = rdy_q;
    assign oREPEAT     = rpt_q;
    assign oHELD       = held_q;
    assign oERR        = err_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
`timescale 1ns/1ps
module tb_ir_nec_decoder;

    // 2 MHz clock gives two cycles per tick; TIME_DIV=40 scales the NEC widths.
    localparam int TICK_NS = 20;
    localparam int LM   = 225;   // 9000/40
    localparam int LS   = 112;   // 4500/40
    localparam int RS   = 56;    // 2250/40
    localparam int BM   = 14;    // 562/40
    localparam int ZERO = 14;    // 562/40
    localparam int ONE  = 42;    // 1687/40

    localparam logic [1:0] K_RDY = 2'd0;
    localparam logic [1:0] K_RPT = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic        clk, rst_n, ir;
    logic [31:0] oDATA;
    logic        oDATA_READY, oREPEAT, oHELD, oERR;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    exp_t sb_q[$];

    ir_nec_decoder #(
        .CLK_HZ        (2_000_000),
        .TOL_PCT       (25),
        .CHECK_CMD_INV (1),
        .CHECK_ADDR_INV(0),
        .REPEAT_WIN_MS (120),
        .TIMEOUT_US    (12000),
        .TIME_DIV      (40)
    ) dut (
        .iCLK        (clk),
        .iRST_n      (rst_n),
        .iIRDA       (ir),
        .oDATA       (oDATA),
        .oDATA_READY (oDATA_READY),
        .oREPEAT     (oREPEAT),
        .oHELD       (oHELD),
        .oERR        (oERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [1:0] kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        #(n * TICK_NS);
    endtask

    task automatic mark(input int n);
        ir = 1'b0;
        ticks(n);
    endtask

    task automatic space(input int n);
        ir = 1'b1;
        ticks(n);
    endtask

    task automatic send_bits(input logic [31:0] d, input int nbits, input int pct);
        for (int i = 0; i < nbits; i++) begin
            mark(BM * pct / 100);
            space(d[i] ? ONE * pct / 100 : ZERO * pct / 100);
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input int pct);
        mark(LM * pct / 100);
        space(LS * pct / 100);
        send_bits(d, 32, pct);
        mark(BM * pct / 100);
        ir = 1'b1;
    endtask

    task automatic send_repeat();
        mark(LM);
        space(RS);
        mark(BM);
        ir = 1'b1;
    endtask

    // Monitor: every output pulse must match the oldest expected response.
    initial begin
        forever begin
            int         n;
            logic [1:0] k;
            exp_t       e;
            @(negedge clk);
            if (rst_n) begin
                n = int'(oDATA_READY) + int'(oREPEAT) + int'(oERR);
                if (n > 0) begin
                    pulses++;
                    k = oDATA_READY ? K_RDY : (oREPEAT ? K_RPT : K_ERR);
                    checks++;
                    if (n > 1) begin
                        errors++;
                        $display("FAIL pulse_overlap: rdy=%0b rpt=%0b err=%0b, required only one",
                                 oDATA_READY, oREPEAT, oERR);
                    end else if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse: kind=%0d, required no pulse", k);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.kind != k) begin
                            errors++;
                            $display("FAIL pulse_kind: got %0d, expected %0d", k, e.kind);
                        end else if (k == K_RDY) begin
                            checks++;
                            if (oDATA !== e.data) begin
                                errors++;
                                $display("FAIL ready_data: got %h, expected %h", oDATA, e.data);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int p;
        ir    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data",  oDATA,       32'h0);
        check("rst_ready", {31'd0, oDATA_READY}, 32'd0);
        check("rst_repeat",{31'd0, oREPEAT},     32'd0);
        check("rst_held",  {31'd0, oHELD},       32'd0);
        check("rst_err",   {31'd0, oERR},        32'd0);
        rst_n = 1'b1;
        ticks(20);

        // Isolated repeat while not held: silently ignored.
        p = pulses;
        send_repeat();
        ticks(100);
        check("iso_repeat_pulses", pulses, p);
        check("iso_repeat_held", {31'd0, oHELD}, 32'd0);

        // Nominal frame addr=00 cmd=01 (1695 ticks long).
        expect_pulse(K_RDY, 32'hFE01FF00);
        send_frame(32'hFE01FF00, 100);
        ticks(5);
        check("frame1_data", oDATA, 32'hFE01FF00);
        check("frame1_held", {31'd0, oHELD}, 32'd1);

        // Three repeats at 108 ms (2700 tick) start-to-start spacing.
        ticks(2700 - 1695 - 5);
        for (int r = 0; r < 3; r++) begin
            expect_pulse(K_RPT, 32'h0);
            send_repeat();
            if (r < 2) ticks(2700 - 295);
        end
        ticks(2900);
        check("hold_before_expiry", {31'd0, oHELD}, 32'd1);
        ticks(200);
        check("hold_after_expiry", {31'd0, oHELD}, 32'd0);
        check("repeat_data_kept", oDATA, 32'hFE01FF00);

        // Bad command checksum.
        expect_pulse(K_ERR, 32'h0);
        send_frame(32'hFF01FF00, 100);
        ticks(5);
        check("badcks_data_kept", oDATA, 32'hFE01FF00);
        check("badcks_held", {31'd0, oHELD}, 32'd0);

        // Short leader mark (6000 us -> 150 ticks), then a good frame.
        expect_pulse(K_ERR, 32'h0);
        mark(150);
        ir = 1'b1;
        ticks(200);
        expect_pulse(K_RDY, 32'hCB34ED12);
        send_frame(32'hCB34ED12, 100);
        ticks(5);
        check("after_shortlead_data", oDATA, 32'hCB34ED12);

        // All widths +20%.
        expect_pulse(K_RDY, 32'hF8077F80);
        send_frame(32'hF8077F80, 120);
        ticks(5);
        check("slow_frame_data", oDATA, 32'hF8077F80);

        // Line held low 15 ms (375 ticks) mid-frame: error after 300 ticks.
        expect_pulse(K_ERR, 32'h0);
        mark(LM);
        space(LS);
        send_bits(32'h0000_0005, 5, 100);
        p = pulses;
        mark(290);
        check("timeout_not_early", pulses, p);
        ticks(85);
        check("timeout_fired", pulses, p + 1);
        space(50);

        // Reset asserted during bit 17 of a frame.
        mark(LM);
        space(LS);
        send_bits(32'hFE01FF00, 17, 100);
        ir = 1'b0;
        ticks(5);
        check("held_before_reset", {31'd0, oHELD}, 32'd1);
        rst_n = 1'b0;
        ir    = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_data",  oDATA, 32'h0);
        check("midrst_flags", {28'd0, oDATA_READY, oREPEAT, oHELD, oERR}, 32'd0);
        rst_n = 1'b1;
        ticks(50);
        expect_pulse(K_RDY, 32'hFE01FF00);
        send_frame(32'hFE01FF00, 100);
        ticks(5);
        check("postrst_data", oDATA, 32'hFE01FF00);
        check("postrst_held", {31'd0, oHELD}, 32'd1);

        ticks(20);
        check("pending_expected", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
